// File: rtl/multi_ch_sync_edge_detect.sv
// Per-channel async-to-clk_fast synchroniser with mode-selected edge detection, pulse, sticky flag and saturating count.
// Input change to edge_pulse is SYNC_STAGES cycles (+1 sampling uncertainty); no backpressure, events are never stalled.
`timescale 1ns/1ps
module multi_ch_sync_edge_detect #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter bit RST_VAL     = 1'b0,
  parameter bit RST_MASK    = 1'b1
) (
  input  logic                  clk_fast,
  input  logic                  rst_n,
  input  logic [CH-1:0]         data_from_slow,
  input  logic [2*CH-1:0]       edge_mode,
  input  logic [CH-1:0]         sticky_clr,
  input  logic [CH-1:0]         cnt_clr,
  output logic [CH-1:0]         data_to_fast,
  output logic [CH-1:0]         edge_pulse,
  output logic [CH-1:0]         edge_sticky,
  output logic [CH*CNT_W-1:0]   edge_cnt
);

  localparam int MW = $clog2(SYNC_STAGES + 2);
  localparam logic [MW-1:0] MASK_INIT = RST_MASK ? MW'(SYNC_STAGES + 1) : '0;
  localparam logic [MW-1:0] MASK_ONE  = MW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  // Shared post-reset blanking window: history settles before any edge is trusted.
  logic [MW-1:0] mask_q;
  logic          masked;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= MASK_INIT;
    end else if (mask_q != '0) begin
      mask_q <= mask_q - MASK_ONE;
    end
  end

  assign masked = (mask_q != '0);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [1:0]             mode_q;
    logic                   sticky_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   rise;
    logic                   fall;
    logic                   hit;
    logic                   pulse;

    // Mode is registered so the decode depends on flops only.
    always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {SYNC_STAGES{RST_VAL}};
        hist_q <= RST_VAL;
        mode_q <= 2'b11;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], data_from_slow[i]};
        hist_q <= sync_q[SYNC_STAGES-1];
        mode_q <= edge_mode[2*i +: 2];
      end
    end

    always_comb begin
      rise = sync_q[SYNC_STAGES-1] & ~hist_q;
      fall = ~sync_q[SYNC_STAGES-1] & hist_q;
      hit  = 1'b0;
      unique case (mode_q)
        MODE_RISE: hit = rise;
        MODE_FALL: hit = fall;
        MODE_BOTH: hit = rise | fall;
        default:   hit = 1'b0;
      endcase
    end

    assign pulse = hit & ~masked;

    // An event in the same cycle as a clear wins: sticky stays set, count restarts at 1.
    always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sticky_q <= pulse | (sticky_q & ~sticky_clr[i]);
        if (pulse) begin
          if (cnt_clr[i]) begin
            cnt_q <= CNT_ONE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end else if (cnt_clr[i]) begin
          cnt_q <= '0;
        end
      end
    end

    assign data_to_fast[i]              = sync_q[SYNC_STAGES-1];
    assign edge_pulse[i]                = pulse;
    assign edge_sticky[i]               = sticky_q;
    assign edge_cnt[i*CNT_W +: CNT_W]   = cnt_q;
  end

endmodule

// File: tb/tb_multi_ch_sync_edge_detect.sv
// Directed bench: stimulus pushes expected pulse windows into a scoreboard, a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_multi_ch_sync_edge_detect;
  localparam int CH    = 4;
  localparam int CNT_W = 8;

  logic                 clk_fast = 1'b0;
  logic                 clk_slow = 1'b0;
  logic                 rst_n;
  logic [CH-1:0]        din, sclr, cclr;
  logic [2*CH-1:0]      mode;
  logic [CH-1:0]        dtf, pls, stk;
  logic [CH*CNT_W-1:0]  cnt;
  logic [CH-1:0]        nm_dtf, nm_pls, nm_stk;
  logic [CH*CNT_W-1:0]  nm_cnt;

  always #3  clk_fast = ~clk_fast;
  always #10 clk_slow = ~clk_slow;

  multi_ch_sync_edge_detect u_dut (
    .clk_fast(clk_fast), .rst_n(rst_n), .data_from_slow(din), .edge_mode(mode),
    .sticky_clr(sclr), .cnt_clr(cclr), .data_to_fast(dtf), .edge_pulse(pls),
    .edge_sticky(stk), .edge_cnt(cnt)
  );

  multi_ch_sync_edge_detect #(.RST_MASK(1'b0)) u_nm (
    .clk_fast(clk_fast), .rst_n(rst_n), .data_from_slow(din), .edge_mode(mode),
    .sticky_clr(sclr), .cnt_clr(cclr), .data_to_fast(nm_dtf), .edge_pulse(nm_pls),
    .edge_sticky(nm_stk), .edge_cnt(nm_cnt)
  );

  int cyc = 0;
  always @(posedge clk_fast) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int lo;
    int hi;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_p[CH];
  int   prev_p[CH];

  task automatic expect_pulse(input int ch, input int c0);
    exp_t e;
    e.ch = ch;
    e.lo = c0 + 2;
    e.hi = c0 + 3;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_fast);
  endtask

  // Monitor: every pulse must match the oldest pending window of its channel; stale windows are misses.
  initial begin
    int idx;
    for (int c = 0; c < CH; c++) begin
      last_p[c] = 0;
      prev_p[c] = 0;
    end
    forever begin
      @(negedge clk_fast);
      for (int c = 0; c < CH; c++) begin
        if (pls[c] === 1'b1) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].ch == c) idx = k;
          end
          n_vec++;
          if (idx < 0) begin
            n_err++;
            $display("FAIL unexpected_pulse ch%0d: pulse at cycle %0d, none expected", c, cyc);
          end else begin
            if (cyc < sb[idx].lo || cyc > sb[idx].hi) begin
              n_err++;
              $display("FAIL pulse_time ch%0d: cycle %0d, expected %0d..%0d", c, cyc, sb[idx].lo, sb[idx].hi);
            end
            sb.delete(idx);
          end
          prev_p[c] = last_p[c];
          last_p[c] = cyc;
        end
      end
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].hi < cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL missing_pulse ch%0d: no pulse by cycle %0d, expected %0d..%0d", sb[k].ch, cyc, sb[k].lo, sb[k].hi);
          sb.delete(k);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    int np_n[CH];
    int np_at[CH];

    rst_n = 1'b0;
    din   = '0;
    sclr  = '0;
    cclr  = '0;
    mode  = {2'b00, 2'b11, 2'b01, 2'b00};
    #20;
    check("rst_dtf",    dtf, 0);
    check("rst_pulse",  pls, 0);
    check("rst_sticky", stk, 0);
    check("rst_cnt",    cnt, 0);
    @(negedge clk_fast);
    rst_n = 1'b1;
    cycles(10);

    // single rising edge on ch0
    @(posedge clk_slow);
    din[0] = 1'b1;
    expect_pulse(0, cyc);
    cycles(8);
    check("t1_sticky0", stk[0], 1);
    check("t1_cnt0",    cnt[0 +: CNT_W], 1);
    check("t1_dtf0",    dtf[0], 1);
    check("t1_sb_empty", sb.size(), 0);

    // ch1: falling-only, then both edges
    @(posedge clk_slow);
    din[1] = 1'b1;
    @(posedge clk_slow);
    din[1] = 1'b0;
    expect_pulse(1, cyc);
    cycles(8);
    check("t2_cnt1_fall", cnt[CNT_W +: CNT_W], 1);
    mode[3:2] = 2'b10;
    cycles(3);
    @(posedge clk_slow);
    din[1] = 1'b1;
    expect_pulse(1, cyc);
    @(posedge clk_slow);
    din[1] = 1'b0;
    expect_pulse(1, cyc);
    cycles(8);
    check("t2_cnt1_both", cnt[CNT_W +: CNT_W], 3);
    check("t2_gap_ge3", ((last_p[1] - prev_p[1]) >= 3), 1);

    // ch2 off: level tracks, no events
    repeat (5) begin
      @(posedge clk_slow);
      din[2] = ~din[2];
    end
    cycles(8);
    check("t3_dtf2",    dtf[2], 1);
    check("t3_sticky2", stk[2], 0);
    check("t3_cnt2",    cnt[2*CNT_W +: CNT_W], 0);

    // ch3 saturation and clear/event collisions
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_fast);
      din[3] = 1'b1;
      expect_pulse(3, cyc);
      cycles(2);
      din[3] = 1'b0;
      cycles(1);
    end
    cycles(6);
    check("t4_cnt3_sat", cnt[3*CNT_W +: CNT_W], 255);
    @(negedge clk_fast);
    din[3] = 1'b1;
    expect_pulse(3, cyc);
    cycles(2);
    cclr[3] = 1'b1;
    sclr[3] = 1'b1;
    cycles(1);
    cclr[3] = 1'b0;
    sclr[3] = 1'b0;
    check("t4_cnt3_clr_evt",    cnt[3*CNT_W +: CNT_W], 1);
    check("t4_sticky3_clr_evt", stk[3], 1);
    din[3] = 1'b0;
    cycles(4);
    sclr[3] = 1'b1;
    cycles(1);
    sclr[3] = 1'b0;
    check("t4_sticky3_clr", stk[3], 0);
    cclr[3] = 1'b1;
    cycles(1);
    cclr[3] = 1'b0;
    check("t4_cnt3_clr", cnt[3*CNT_W +: CNT_W], 0);

    // inputs high through reset release: masked vs unmasked instance
    mode = '0;
    cycles(3);
    check("t5_sb_empty", sb.size(), 0);
    rst_n = 1'b0;
    din   = '1;
    cycles(3);
    rst_n = 1'b1;
    r = cyc;
    for (int c = 0; c < CH; c++) begin
      np_n[c]  = 0;
      np_at[c] = -1;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_fast);
      for (int c = 0; c < CH; c++) begin
        if (nm_pls[c] === 1'b1) begin
          np_n[c]++;
          np_at[c] = cyc - r;
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      check($sformatf("t5_nomask_cnt_ch%0d", c), np_n[c], 1);
      check($sformatf("t5_nomask_at_ch%0d", c), np_at[c], 2);
    end
    check("t5_mask_sticky", stk, 0);
    check("t5_mask_cnt",    cnt, 0);

    // reset while an edge is in flight on ch0
    cycles(2);
    din[0] = 1'b0;
    cycles(4);
    check("t6_pre_dtf", dtf, 4'b1110);
    din[0] = 1'b1;
    cycles(1);
    rst_n = 1'b0;
    #1;
    check("t6_async_dtf",   dtf, 0);
    check("t6_async_pulse", pls, 0);
    check("t6_async_cnt",   cnt, 0);
    din = '0;
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
    check("t6_post_sticky", stk, 0);
    check("t6_post_cnt",    cnt, 0);
    check("t6_post_dtf",    dtf, 0);
    check("end_sb_empty",   sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
